// File: rtl/atari7800_pkg.sv
// Shared types and constants for the Atari 7800 MARIA bus-side logic.
package atari7800_pkg;

  // Bus ownership sequence: CPU owns in IDLE, halted in HALT_WAIT,
  // MARIA drives in DMA, nobody drives in RELEASE.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HALT_WAIT = 2'd1,
    DMA       = 2'd2,
    RELEASE   = 2'd3
  } arb_state_t;

  localparam int DMA_CNT_W = 9;

endpackage

// File: rtl/maria_bus_arbiter_wsync_hold.sv
// WSYNC ready hold: a WSYNC write drops CPU RDY until horizontal blank starts.
// The WSYNC write (hold set) beats a coincident hblank start.
module maria_bus_arbiter_wsync_hold (
  input  logic pclk_2,
  input  logic reset_b,
  input  logic wsync_hit,
  input  logic hblank_start,
  output logic ready
);

  // Set/reset flop; the hold request wins when both arrive together.
  always_ff @(posedge pclk_2 or negedge reset_b) begin
    if (!reset_b)          ready <= 1'b1;
    else if (wsync_hit)    ready <= 1'b0;
    else if (hblank_start) ready <= 1'b1;
  end

endmodule

// File: rtl/maria_bus_arbiter.sv
// Address-bus arbiter between the 6502 and MARIA display-list DMA.
// Halts the CPU, waits HALT_LATENCY cycles, grants the bus, enforces a
// per-grant cycle budget and inserts a one-cycle turnaround on release.
module maria_bus_arbiter
  import atari7800_pkg::*;
#(
  parameter int HALT_LATENCY   = 2,
  parameter int MAX_DMA_CYCLES = 400
) (
  input  logic                 pclk_2,
  input  logic                 reset_b,
  input  logic                 dma_req,
  input  logic                 dma_done,
  input  logic                 wsync_hit,
  input  logic                 hblank_start,
  output logic                 halt_b,
  output logic                 drive_AB,
  output logic                 dma_grant,
  output logic                 ready,
  output logic                 dma_overrun,
  output logic [DMA_CNT_W-1:0] last_dma_len
);

  localparam logic [2:0]           HCNT_LOAD = 3'(HALT_LATENCY - 1);
  localparam logic [DMA_CNT_W-1:0] DCNT_LAST = DMA_CNT_W'(MAX_DMA_CYCLES - 1);
  localparam logic [DMA_CNT_W-1:0] BUDGET    = DMA_CNT_W'(MAX_DMA_CYCLES);
  localparam logic [DMA_CNT_W-1:0] DCNT_SAT  = '1;

  arb_state_t           state;
  logic [2:0]           hcnt;
  logic [DMA_CNT_W-1:0] dcnt;

  // Ownership FSM; halt_b / drive_AB are registered with the state change so
  // they always reflect the state being entered.
  always_ff @(posedge pclk_2 or negedge reset_b) begin
    if (!reset_b) begin
      state        <= IDLE;
      hcnt         <= '0;
      dcnt         <= '0;
      halt_b       <= 1'b1;
      drive_AB     <= 1'b0;
      dma_overrun  <= 1'b0;
      last_dma_len <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dma_req) begin
            state  <= HALT_WAIT;
            hcnt   <= HCNT_LOAD;
            halt_b <= 1'b0;
          end
        end
        HALT_WAIT: begin
          // Withdrawal still passes through RELEASE so halt_b rises cleanly.
          if (!dma_req) begin
            state <= RELEASE;
          end else if (hcnt == 3'd0) begin
            state    <= DMA;
            dcnt     <= '0;
            drive_AB <= 1'b1;
          end else begin
            hcnt <= hcnt - 3'd1;
          end
        end
        DMA: begin
          if (dcnt != DCNT_SAT) dcnt <= dcnt + DMA_CNT_W'(1);
          if (dma_done) begin
            state        <= RELEASE;
            drive_AB     <= 1'b0;
            last_dma_len <= dcnt + DMA_CNT_W'(1);
          end else if (dcnt == DCNT_LAST) begin
            state        <= RELEASE;
            drive_AB     <= 1'b0;
            last_dma_len <= BUDGET;
            dma_overrun  <= 1'b1;
          end
        end
        RELEASE: begin
          state  <= IDLE;
          halt_b <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          halt_b   <= 1'b1;
          drive_AB <= 1'b0;
        end
      endcase
    end
  end

  assign dma_grant = drive_AB;

  maria_bus_arbiter_wsync_hold u_wsync_hold (
    .pclk_2       (pclk_2),
    .reset_b      (reset_b),
    .wsync_hit    (wsync_hit),
    .hblank_start (hblank_start),
    .ready        (ready)
  );

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// Bench for maria_bus_arbiter: grant timing, budget, withdrawal, WSYNC, reset.
module tb_maria_bus_arbiter;

  localparam int HL   = 2;
  localparam int MAXC = 16;

  logic       pclk_2 = 1'b0;
  logic       reset_b;
  logic       dma_req, dma_done, wsync_hit, hblank_start;
  logic       halt_b, drive_AB, dma_grant, ready, dma_overrun;
  logic [8:0] last_dma_len;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int len;
    bit ovr;
  } exp_t;

  exp_t q[$];
  bit   m_ovr = 1'b0;
  int   gcnt  = 0;
  bit   prev_drive = 1'b0;

  always #5 pclk_2 = ~pclk_2;

  maria_bus_arbiter #(.HALT_LATENCY(HL), .MAX_DMA_CYCLES(MAXC)) dut (
    .pclk_2       (pclk_2),
    .reset_b      (reset_b),
    .dma_req      (dma_req),
    .dma_done     (dma_done),
    .wsync_hit    (wsync_hit),
    .hblank_start (hblank_start),
    .halt_b       (halt_b),
    .drive_AB     (drive_AB),
    .dma_grant    (dma_grant),
    .ready        (ready),
    .dma_overrun  (dma_overrun),
    .last_dma_len (last_dma_len)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge pclk_2);
    #1;
  endtask

  // Scoreboard: on each grant end, compare against the queued expectation.
  always @(negedge pclk_2) begin
    if (!reset_b) begin
      gcnt       = 0;
      prev_drive = 1'b0;
    end else begin
      if (drive_AB) begin
        gcnt++;
        chk("halt_cover", halt_b, 0);
      end
      if (prev_drive && !drive_AB) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("last_dma_len", last_dma_len, e.len);
          chk("dma_overrun", dma_overrun, e.ovr);
          chk("grant_cycles", gcnt, e.len);
        end
        gcnt = 0;
      end
      prev_drive = drive_AB;
    end
  end

  // One full request/grant/release; done pulses on grant cycle 'len'.
  task automatic grant(input int len, input bit give_done);
    exp_t e;
    bit   fin;
    fin   = give_done && (len <= MAXC);
    e.len = fin ? len : MAXC;
    if (!fin) m_ovr = 1'b1;
    e.ovr = m_ovr;
    q.push_back(e);
    dma_req = 1'b1;
    tick(1);
    chk("req_halt", halt_b, 0);
    chk("req_nogrant", drive_AB, 0);
    for (int i = 1; i < HL; i++) begin
      tick(1);
      chk("hw_nogrant", drive_AB, 0);
    end
    tick(1);
    chk("grant", drive_AB, 1);
    chk("grant_echo", dma_grant, 1);
    for (int k = 1; k <= 40; k++) begin
      if (give_done && k == len) dma_done = 1'b1;
      tick(1);
      dma_done = 1'b0;
      if (!drive_AB) break;
    end
    dma_req = 1'b0;
    chk("release", drive_AB, 0);
    chk("rel_halt", halt_b, 0);
    tick(1);
    chk("idle_halt", halt_b, 1);
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_b = 1'b0; dma_req = 1'b0; dma_done = 1'b0;
    wsync_hit = 1'b0; hblank_start = 1'b0;
    tick(2);
    chk("rst_halt_b", halt_b, 1);
    chk("rst_drive", drive_AB, 0);
    chk("rst_grant", dma_grant, 0);
    chk("rst_ready", ready, 1);
    chk("rst_ovr", dma_overrun, 0);
    chk("rst_len", last_dma_len, 0);
    reset_b = 1'b1;
    tick(3);

    // Normal grants, done exactly at budget expiry, minimal grant.
    grant(10, 1'b1);
    grant(MAXC, 1'b1);
    grant(1, 1'b1);
    // Budget overrun, then a normal grant keeps the sticky flag.
    grant(20, 1'b0);
    grant(5, 1'b1);
    grant(30, 1'b1);

    // Request withdrawn during halt wait: no grant, halt_b back after 2.
    dma_req = 1'b1;
    tick(1);
    chk("wd_halt", halt_b, 0);
    dma_req = 1'b0;
    tick(1);
    chk("wd_nogrant", drive_AB, 0);
    chk("wd_rel_halt", halt_b, 0);
    tick(1);
    chk("wd_idle_halt", halt_b, 1);
    chk("wd_idle_drive", drive_AB, 0);
    tick(3);

    // WSYNC hold.
    wsync_hit = 1'b1;
    tick(1);
    wsync_hit = 1'b0;
    chk("ws_hold", ready, 0);
    tick(5);
    chk("ws_still", ready, 0);
    hblank_start = 1'b1;
    tick(1);
    hblank_start = 1'b0;
    chk("ws_release", ready, 1);
    hblank_start = 1'b1;
    tick(1);
    hblank_start = 1'b0;
    chk("hb_noop", ready, 1);
    wsync_hit = 1'b1; hblank_start = 1'b1;
    tick(1);
    wsync_hit = 1'b0; hblank_start = 1'b0;
    chk("ws_both", ready, 0);
    tick(4);
    chk("ws_both_wait", ready, 0);
    hblank_start = 1'b1;
    tick(1);
    hblank_start = 1'b0;
    chk("ws_both_release", ready, 1);

    // Reset asserted mid-DMA with RDY held low.
    wsync_hit = 1'b1;
    tick(1);
    wsync_hit = 1'b0;
    dma_req = 1'b1;
    tick(HL + 1);
    chk("mid_grant", drive_AB, 1);
    #2 reset_b = 1'b0;
    #1;
    chk("mid_rst_drive", drive_AB, 0);
    chk("mid_rst_grant", dma_grant, 0);
    chk("mid_rst_halt", halt_b, 1);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_ovr", dma_overrun, 0);
    chk("mid_rst_len", last_dma_len, 0);
    dma_req = 1'b0;
    m_ovr = 1'b0;
    tick(2);
    reset_b = 1'b1;
    tick(2);
    grant(4, 1'b1);

    tick(3);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
